multicycle_ctrl_fsm: RTL and testbench

Main sequencing state machine for the multicycle ARM datapath. It decodes the instruction class from `Op` and `Funct` and steps the shared ALU, memory port and register file through fetch, decode, execute, memory and writeback states. It emits the per-cycle mux selects and the unconditioned write strobes (`RegW`, `MemW`, `NextPC`, `Branch`), which then pass through the condition-logic stage. It also handles a variable-latency memory port through a `MemReady` handshake.

---
 rtl/multicycle_ctrl_fsm_if.sv | 44 ++++
 rtl/multicycle_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//
// Bundle between the multicycle control FSM and the ARM datapath.
//   Op, Funct, MemReady       : instruction class/bits and memory handshake,
//                               driven by the datapath toward the FSM.
//   IRWrite, NextPC, Branch,
//   RegW, MemW                : unconditioned write strobes from the FSM.
//   AdrSrc, ALUSrcA, ALUSrcB,
//   ResultSrc, ALUOp          : per-cycle datapath mux selects from the FSM.
//   State                     : registered state vector, for debug/coverage.
//
// Modports:
//   master : the control FSM (consumes decode inputs, drives controls).
//   slave  : the datapath side (drives decode inputs, consumes controls).
// ----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       IRWrite;
   logic       NextPC;
   logic       Branch;
   logic       RegW;
   logic       MemW;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic [3:0] State;

   modport master (
      input  Op, Funct, MemReady,
      output IRWrite, NextPC, Branch, RegW, MemW,
      output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State
   );

   modport slave (
      output Op, Funct, MemReady,
      input  IRWrite, NextPC, Branch, RegW, MemW,
      input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, State
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main sequencing FSM for the multicycle ARM datapath. Decodes the
// instruction class from Op/Funct and steps fetch, decode, execute, memory
// and writeback states, emitting mux selects and unconditioned write strobes
// that feed the condition-logic stage. Memory accesses in FETCH, MEMRD and
// MEMWR wait on the MemReady handshake.
//
// Ports:
//   clk    : system clock, rising edge.
//   reset  : asynchronous, active-low; forces FETCH and drops all strobes.
//   bus    : multicycle_ctrl_fsm_if.master (decode inputs, controls, State).
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_ctrl_fsm_if.master       bus
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   logic [3:0] state_q;
   logic [3:0] state_d;

   // Raw strobes before the reset gate.
   logic irwrite_raw;
   logic nextpc_raw;
   logic branch_raw;
   logic regw_raw;
   logic memw_raw;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every combinational output is given a default before the case so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               default: state_d = S_FETCH;  // illegal class: abandon
            endcase
         end
         S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
         S_MEMWB:  state_d = S_FETCH;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         default:  state_d = S_FETCH;  // encodings 10-15 recover to FETCH
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode (Moore, except IRWrite/NextPC in FETCH)
   // ---------------------------------------------------------------------
   always_comb begin
      irwrite_raw   = 1'b0;
      nextpc_raw    = 1'b0;
      branch_raw    = 1'b0;
      regw_raw      = 1'b0;
      memw_raw      = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.ALUOp     = 1'b0;
      case (state_q)
         S_FETCH: begin
            // Instruction latch and PC+4 happen only on the cycle the
            // memory actually returns the fetch.
            irwrite_raw   = bus.MemReady;
            nextpc_raw    = bus.MemReady;
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         S_DECODE: begin
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
         end
         S_MEMADR: begin
            bus.ALUSrcB   = 2'b01;
         end
         S_MEMRD: begin
            bus.AdrSrc    = 1'b1;
         end
         S_MEMWB: begin
            bus.ResultSrc = 2'b01;
            regw_raw      = 1'b1;
         end
         S_MEMWR: begin
            // Held for the whole stall so the memory sees a stable request.
            bus.AdrSrc    = 1'b1;
            memw_raw      = 1'b1;
         end
         S_EXECR: begin
            bus.ALUOp     = 1'b1;
         end
         S_EXECI: begin
            bus.ALUSrcB   = 2'b01;
            bus.ALUOp     = 1'b1;
         end
         S_ALUWB: begin
            regw_raw      = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            branch_raw    = 1'b1;
         end
         default: ;  // unreachable encodings: everything stays 0
      endcase
   end

   // Strobes are gated by reset directly so an asynchronous assertion kills
   // any in-flight write in the same cycle, without waiting for state_q.
   assign bus.IRWrite = irwrite_raw & reset;
   assign bus.NextPC  = nextpc_raw  & reset;
   assign bus.Branch  = branch_raw  & reset;
   assign bus.RegW    = regw_raw    & reset;
   assign bus.MemW    = memw_raw    & reset;
   assign bus.State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Directed bench for multicycle_ctrl_fsm. Inputs change just after the
// falling edge; outputs are compared 1 time unit later, well away from the
// rising edge. Each row of a sequence checks State, the strobe vector and
// the select vector for one clock cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

   logic clk;
   logic reset;

   multicycle_ctrl_fsm_if bus_if ();

   multicycle_ctrl_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Strobe vector: {IRWrite, NextPC, Branch, RegW, MemW}
   localparam logic [4:0] ST_NONE  = 5'b00000;
   localparam logic [4:0] ST_FETCH = 5'b11000;
   localparam logic [4:0] ST_BR    = 5'b00100;
   localparam logic [4:0] ST_REGW  = 5'b00010;
   localparam logic [4:0] ST_MEMW  = 5'b00001;

   // Select vector: {AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp}
   localparam logic [7:0] SL_FETCH  = 8'b0_01_10_10_0;  // FETCH and DECODE
   localparam logic [7:0] SL_MEMADR = 8'b0_00_01_00_0;
   localparam logic [7:0] SL_MEMADR_ALT = 8'b0_00_01_00_0;
   localparam logic [7:0] SL_ADR1   = 8'b1_00_00_00_0;  // MEMRD and MEMWR
   localparam logic [7:0] SL_MEMWB  = 8'b0_00_00_01_0;
   localparam logic [7:0] SL_EXECR  = 8'b0_00_00_00_1;
   localparam logic [7:0] SL_EXECI  = 8'b0_00_01_00_1;
   localparam logic [7:0] SL_ZERO   = 8'b0_00_00_00_0;  // ALUWB
   localparam logic [7:0] SL_BRANCH = 8'b0_00_01_10_0;

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, actual, expected, $time);
      end
   endtask

   function automatic logic [4:0] strobes();
      return {bus_if.IRWrite, bus_if.NextPC, bus_if.Branch,
              bus_if.RegW, bus_if.MemW};
   endfunction

   function automatic logic [7:0] selects();
      return {bus_if.AdrSrc, bus_if.ALUSrcA, bus_if.ALUSrcB,
              bus_if.ResultSrc, bus_if.ALUOp};
   endfunction

   // One clock cycle: apply inputs, check outputs mid-cycle, move to the
   // next falling edge. Called aligned to a falling edge.
   task automatic cyc(input string tag, input logic mr, input logic [1:0] op,
                      input logic [5:0] funct, input logic [3:0] exp_state,
                      input logic [4:0] exp_strb, input logic [7:0] exp_sel);
      bus_if.MemReady = mr;
      bus_if.Op       = op;
      bus_if.Funct    = funct;
      #1;
      check({tag, ".state"}, 32'(bus_if.State), 32'(exp_state));
      check({tag, ".strb"},  32'(strobes()),    32'(exp_strb));
      check({tag, ".sel"},   32'(selects()),    32'(exp_sel));
      @(negedge clk);
   endtask

   initial begin
      reset           = 1'b0;
      bus_if.MemReady = 1'b1;
      bus_if.Op       = 2'b00;
      bus_if.Funct    = 6'b000000;

      // Reset held with MemReady=1: FETCH selects, every strobe 0.
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst.state", 32'(bus_if.State), 32'd0);
      check("rst.strb",  32'(strobes()),    32'(ST_NONE));
      check("rst.sel",   32'(selects()),    32'(SL_FETCH));
      @(negedge clk);
      reset = 1'b1;

      // DP register: 0,1,6,8,0. Op/Funct scrambled outside sampled states.
      cyc("dpr0", 1'b1, 2'b10, 6'b111111, 4'd0, ST_FETCH, SL_FETCH);
      cyc("dpr1", 1'b1, 2'b00, 6'b001000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("dpr6", 1'b0, 2'b01, 6'b100001, 4'd6, ST_NONE,  SL_EXECR);
      cyc("dpr8", 1'b0, 2'b10, 6'b100001, 4'd8, ST_REGW,  SL_ZERO);

      // DP immediate: 0,1,7,8,0.
      cyc("dpi0", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("dpi1", 1'b1, 2'b00, 6'b100000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("dpi7", 1'b1, 2'b00, 6'b000000, 4'd7, ST_NONE,  SL_EXECI);
      cyc("dpi8", 1'b1, 2'b00, 6'b000000, 4'd8, ST_REGW,  SL_ZERO);

      // LDR with 2 stall cycles in MEMRD: 0,1,2,3,3,3,4,0.
      cyc("ldr0", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("ldr1", 1'b1, 2'b01, 6'b000001, 4'd1, ST_NONE,  SL_FETCH);
      cyc("ldr2", 1'b1, 2'b01, 6'b000001, 4'd2, ST_NONE,  SL_MEMADR);
      cyc("ldr3a", 1'b0, 2'b01, 6'b000000, 4'd3, ST_NONE, SL_ADR1);
      cyc("ldr3b", 1'b0, 2'b01, 6'b000000, 4'd3, ST_NONE, SL_ADR1);
      cyc("ldr3c", 1'b1, 2'b01, 6'b000000, 4'd3, ST_NONE, SL_ADR1);
      cyc("ldr4", 1'b1, 2'b11, 6'b000000, 4'd4, ST_REGW,  SL_MEMWB);

      // STR with 1 stall cycle in MEMWR: 0,1,2,5,5,0; MemW for 2 cycles.
      cyc("str0", 1'b1, 2'b01, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("str1", 1'b1, 2'b01, 6'b000000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("str2", 1'b1, 2'b01, 6'b000000, 4'd2, ST_NONE,  SL_MEMADR_ALT);
      cyc("str5a", 1'b0, 2'b01, 6'b000000, 4'd5, ST_MEMW, SL_ADR1);
      cyc("str5b", 1'b1, 2'b01, 6'b000000, 4'd5, ST_MEMW, SL_ADR1);

      // Branch: 0,1,9,0.
      cyc("br0", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("br1", 1'b1, 2'b10, 6'b000000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("br9", 1'b1, 2'b00, 6'b000000, 4'd9, ST_BR,    SL_BRANCH);

      // Illegal: 0,1,0.
      cyc("ill0", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("ill1", 1'b1, 2'b11, 6'b100001, 4'd1, ST_NONE,  SL_FETCH);

      // Fetch stall of 3 cycles, then fetch completes, then illegal op.
      cyc("fst0a", 1'b0, 2'b00, 6'b000000, 4'd0, ST_NONE,  SL_FETCH);
      cyc("fst0b", 1'b0, 2'b00, 6'b000000, 4'd0, ST_NONE,  SL_FETCH);
      cyc("fst0c", 1'b0, 2'b00, 6'b000000, 4'd0, ST_NONE,  SL_FETCH);
      cyc("fst0d", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("fst1", 1'b1, 2'b11, 6'b000000, 4'd1, ST_NONE,  SL_FETCH);

      // Asynchronous reset in the middle of a stalled store.
      cyc("ars0", 1'b1, 2'b01, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("ars1", 1'b1, 2'b01, 6'b000000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("ars2", 1'b1, 2'b01, 6'b000000, 4'd2, ST_NONE,  SL_MEMADR);
      bus_if.MemReady = 1'b0;
      #1;
      check("ars5.state", 32'(bus_if.State), 32'd5);
      check("ars5.memw",  32'(bus_if.MemW),  32'd1);
      #1;
      reset = 1'b0;  // falls mid-cycle, no clock edge involved
      #1;
      check("arsr.memw",  32'(bus_if.MemW),  32'd0);
      check("arsr.state", 32'(bus_if.State), 32'd0);
      check("arsr.sel",   32'(selects()),    32'(SL_FETCH));
      bus_if.MemReady = 1'b1;
      #1;
      check("arsr.strb",  32'(strobes()),    32'(ST_NONE));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Restart after reset: a full branch from FETCH.
      cyc("rs0", 1'b1, 2'b00, 6'b000000, 4'd0, ST_FETCH, SL_FETCH);
      cyc("rs1", 1'b1, 2'b10, 6'b000000, 4'd1, ST_NONE,  SL_FETCH);
      cyc("rs9", 1'b1, 2'b00, 6'b000000, 4'd9, ST_BR,    SL_BRANCH);
      cyc("rs0b", 1'b0, 2'b00, 6'b000000, 4'd0, ST_NONE, SL_FETCH);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
